// File: rtl/seq_div5.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero skips iteration and returns all-ones quotient with the dividend as remainder.
module seq_div5 #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DZ
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e            state_q, state_d;
    // Working dividend; quotient bits shift in at the LSB as dividend bits leave the MSB.
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  pr_q, pr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              dz_q, dz_d;

    logic [WIDTH:0]    pr_shift;
    logic              ge;
    logic [WIDTH-1:0]  pr_step;
    logic [WIDTH-1:0]  quo_step;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        // The remainder after each step is below the divisor, so WIDTH bits of state suffice.
        pr_shift = {pr_q, dvd_q[WIDTH-1]};
        ge       = (pr_shift >= {1'b0, dvs_q});
        pr_step  = ge ? WIDTH'(pr_shift - {1'b0, dvs_q}) : WIDTH'(pr_shift);
        quo_step = {dvd_q[WIDTH-2:0], ge};

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    if (B == '0) begin
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        state_d = StFin;
                    end else begin
                        dvd_d   = A;
                        dvs_d   = B;
                        pr_d    = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                dvd_d = quo_step;
                pr_d  = pr_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    q_d     = quo_step;
                    r_d     = pr_step;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign DZ   = dz_q;
    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);

endmodule

// File: tb/tb_seq_div5.sv
// Scoreboard bench for seq_div5: stimulus pushes expected results, a negedge monitor
// pops and compares on every DONE pulse; handshake timing is checked by the stimulus.
module tb_seq_div5;

    localparam int unsigned W = 5;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         BUSY;
    logic         DONE;
    logic         DZ;

    typedef struct {
        int q;
        int r;
        int dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    seq_div5 #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .A    (A),
        .B    (B),
        .Q    (Q),
        .R    (R),
        .BUSY (BUSY),
        .DONE (DONE),
        .DZ   (DZ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("Q", int'(Q), e.q);
                chk("R", int'(R), e.r);
                chk("DZ", int'(DZ), e.dz);
            end
        end
    end

    // Waits for DONE after the START edge; checks latency and BUSY cycle count.
    task automatic wait_done(input string name, input int lat, input int busy_cyc);
        int cyc;
        int bcnt;
        cyc  = 0;
        bcnt = 0;
        while (cyc < 30) begin
            @(negedge CLK);
            START = 1'b0;
            cyc++;
            if (BUSY) bcnt++;
            if (DONE) break;
        end
        chk({name, "_latency"}, cyc, lat);
        chk({name, "_busy"}, bcnt, busy_cyc);
    endtask

    task automatic do_op(input int a, input int b, input int eq, input int er, input int edz);
        exp_t e;
        @(negedge CLK);
        A     = W'(a);
        B     = W'(b);
        START = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        exp_q.push_back(e);
        if (b == 0) wait_done($sformatf("op%0d_%0d", a, b), 1, 0);
        else wait_done($sformatf("op%0d_%0d", a, b), W + 1, W);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Reset
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_BUSY", int'(BUSY), 0);
        chk("rst_DONE", int'(DONE), 0);
        chk("rst_DZ", int'(DZ), 0);
        RST = 1'b0;

        do_op(23, 5, 4, 3, 0);
        do_op(31, 1, 31, 0, 0);
        do_op(7, 9, 0, 7, 0);
        do_op(0, 5, 0, 0, 0);
        do_op(31, 31, 1, 0, 0);
        do_op(13, 0, 31, 13, 1);
        do_op(10, 3, 3, 1, 0);

        // START during RUN is ignored; START in the IDLE cycle after DONE is accepted.
        @(negedge CLK);
        A     = 5'd30;
        B     = 5'd7;
        START = 1'b1;
        e.q   = 4;
        e.r   = 2;
        e.dz  = 0;
        exp_q.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        chk("hold_Q_in_run", int'(Q), 3);
        @(negedge CLK);
        A     = 5'd1;
        B     = 5'd1;
        START = 1'b1;
        wait_done("ignored_start", W - 1, W - 2);
        do_op(1, 1, 1, 0, 0);

        // Reset mid-operation aborts without DONE.
        @(negedge CLK);
        A     = 5'd29;
        B     = 5'd4;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A     = 5'd0;
        B     = 5'd0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_BUSY", int'(BUSY), 0);
        chk("abort_DONE", int'(DONE), 0);
        chk("abort_Q", int'(Q), 0);
        chk("abort_R", int'(R), 0);
        repeat (W + 3) @(negedge CLK);
        do_op(29, 4, 7, 1, 0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_div5.md
Name: seq_div5

Overview:
- Iterative unsigned restoring divider. It is the inverse-operation companion to the multiplier datapath's partial-product summation.
- Takes a WIDTH-bit dividend and divisor and produces quotient and remainder, one quotient bit per clock.
- Sits beside the multiplier in the 5-bit ALU.
- Start/busy/done handshake to the ALU control FSM.

Parameters:
- WIDTH, 5, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- A  input  WIDTH  dividend; sampled on the accepting edge.
- B  input  WIDTH  divisor; sampled on the accepting edge.
- Q  output  WIDTH  quotient (registered).
- R  output  WIDTH  remainder (registered).
- BUSY  output  1  high while iterating.
- DONE  output  1  one-cycle pulse; Q/R/DZ valid.
- DZ  output  1  divide-by-zero flag for the last result.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at an edge):
  - State becomes IDLE; iteration counter clears.
  - Q=0, R=0, BUSY=0, DONE=0, DZ=0.
  - RST has priority over START.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 with B!=0 at edge e0: latch A into working dividend, B into working divisor; clear partial remainder; count=0; go to RUN. DZ cleared at e0.
  - START=1 with B=0 at edge e0: no iteration. Q=all ones (2^WIDTH-1), R=A, DZ=1; go to FIN.
  - START=0: stay in IDLE.
- RUN: each edge performs one restoring step, MSB of dividend first:
  - pr' = {pr[WIDTH-1:0], dividend_msb}, held in WIDTH+1 bits.
  - If pr' >= divisor: pr = pr' - divisor and shift in quotient bit 1; else pr = pr' and shift in 0.
  - count increments each step.
  - On the edge performing step WIDTH (edge e0+WIDTH): Q and R load the final quotient and remainder; go to FIN.
- FIN: DONE=1 for exactly this one cycle; the next edge returns to IDLE.
- Latency:
  - Normal division: DONE high in the cycle after edge e0+WIDTH, i.e. WIDTH+1 cycles after the START edge.
  - Divide-by-zero: DONE high in the cycle after e0.
- BUSY = 1 exactly in RUN; 0 in IDLE and FIN.
- Q, R and DZ hold the previous result through RUN. They update only on the edge entering FIN, then hold until the next completed operation or reset.
- START is ignored in RUN and FIN; it is not queued. A START in the IDLE cycle right after FIN is accepted, giving a back-to-back rate of one result per WIDTH+2 cycles.
- A and B may change after the accepting edge without effect.
- Arithmetic widths:
  - Partial remainder is WIDTH+1 bits internally; the final remainder is always < B and fits WIDTH bits.
  - No overflow is possible for unsigned operands.
- Reset mid-operation (RST in RUN or FIN): immediate abort to IDLE. No DONE pulse; outputs take their reset values.
- A=0 with B!=0: full WIDTH-step run; Q=0, R=0.

Test Plan:
- Reset: assert RST 2 cycles -> Q=0, R=0, BUSY=0, DONE=0, DZ=0.
- A=23, B=5, START at e0 -> BUSY high for 5 cycles; DONE in cycle after e0+5; Q=4, R=3, DZ=0. A=31, B=1 -> Q=31, R=0. A=7, B=9 -> Q=0, R=7.
- A=13, B=0 -> DONE in cycle after e0; Q=31, R=13, DZ=1, BUSY never high. Next op A=10, B=3 clears DZ and gives Q=3, R=1.
- START pulsed again with A=1, B=1 two cycles into RUN of A=30, B=7:
  - Ignored; result Q=4, R=2.
  - A second START in the IDLE cycle after DONE is accepted.
- RST at e0+3 during A=29, B=4 -> state IDLE next cycle, no DONE pulse, Q=0, R=0. A new START afterwards completes normally with Q=7, R=1.
